adder_vector_logger: RTL
========================

# adder_vector_logger

Synthesizable capture block that writes adder test vectors: samples the half-adder's inputs and output on a strobe, packs each sample into the 4-bit vector word {a, b, sum[1:0]} and stores it in an internal buffer. It then drains the buffer through a valid/ready read port, so captured vectors can be dumped in the same word format the vector-driven benches load. It also checks each sample against a locally computed expected sum and keeps a mismatch count. It sits beside the half adder, observing its pins.

## Interface
- DEPTH, 6, number of vector words buffered per capture run (2..16)
- AW, 3, pointer width; must satisfy 2^AW >= DEPTH
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a capture run (honoured in IDLE only)
- stop  in  1  end capture early (honoured in CAPTURE only)
- sample_valid  in  1  sample a, b, sum this cycle
- a  in  1  adder operand a
- b  in  1  adder operand b
- sum  in  2  adder result, sum[1]=carry, sum[0]=sum bit
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  rd_data holds a captured word
- rd_data  out  4  word {a, b, sum[1:0]}, bit3=a, bit2=b
- rd_last  out  1  rd_data is the final captured word
- busy  out  1  state is CAPTURE or DRAIN
- full  out  1  DEPTH words captured in this run
- cap_count  out  AW+1  words captured in the current/last run
- err_count  out  AW+1  samples where sum != {a&b, a^b}

## Operation
- States:
  - IDLE: wait for start.
  - CAPTURE: store samples.
  - DRAIN: present buffer contents.
- IDLE -> CAPTURE on start=1. In the same edge: wr_ptr, rd_ptr, cap_count and err_count are cleared to 0, and full is cleared.
- CAPTURE, when sample_valid=1:
  - mem[wr_ptr] <= {a, b, sum}; wr_ptr and cap_count increment.
  - If sum != {a&b, a^b}, err_count increments.
- CAPTURE -> DRAIN when the DEPTH-th word is written; full=1 from the next cycle.
- CAPTURE -> DRAIN on stop=1 with cap_count>0.
- stop=1 and sample_valid=1 in the same cycle: the sample is stored, then the block enters DRAIN.
- CAPTURE -> IDLE on stop=1 with cap_count=0 and no sample that cycle. No read traffic occurs.
- DRAIN:
  - rd_valid=1; rd_data=mem[rd_ptr]; rd_last=1 when rd_ptr==cap_count-1.
  - On rd_valid && rd_ready, rd_ptr increments.
  - Transfer with rd_last=1 -> IDLE.
- Ignored inputs:
  - start is ignored in CAPTURE and DRAIN.
  - sample_valid and stop are ignored in IDLE and DRAIN.
- cap_count, err_count and full hold their values after returning to IDLE until the next start.
- err_count cannot exceed DEPTH. It needs no saturation logic but must be AW+1 bits wide.

## Timing
- Reset values:
  - state IDLE, pointers 0.
  - rd_valid=0, rd_data=0, rd_last=0.
  - busy=0, full=0, cap_count=0, err_count=0.
  - Buffer contents are don't-care.
- Reset mid-run (CAPTURE or DRAIN) aborts immediately; all outputs take their reset values on the next cycle.
- Sample-to-store latency: a word sampled at edge N is counted in cap_count after edge N.
- DRAIN entry:
  - After a stop or the final write at edge N, the block is in DRAIN after edge N.
  - rd_valid=1 in the cycle following edge N, showing mem[0].
- Readout throughput: one word per cycle while rd_ready=1.
- Backpressure: while rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
- End of drain: rd_valid drops the cycle after the last transfer; busy drops in the same cycle.
- rd_data and rd_last are registered or driven from registered state. They never depend combinationally on rd_ready.
- Back-to-back runs: start may be asserted the first IDLE cycle after a drain.

## Test plan
- Full run, correct DUT:
  - Stimulus: start; 6 samples (a,b) = 00,01,10,11,00,11 with correct sums.
  - Response: full=1, cap_count=6, err_count=0.
  - Drain with rd_ready=1 yields 0000,0101,1001,1110,0000,1110; rd_last on the 6th word; busy=0 one cycle later.
- Mismatch detection:
  - Stimulus: sample a=1, b=1, sum=01 among 6 samples.
  - Response: err_count=1; the word is stored as 1101, unmodified.
- Early stop:
  - Stimulus: 3 samples, then stop with sample_valid=1 on the 4th.
  - Response: cap_count=4, full=0; 4 words drained; rd_last on word 4.
  - Stimulus: stop with zero samples.
  - Response: returns to IDLE; rd_valid never asserts.
- Backpressure:
  - Stimulus: during drain, hold rd_ready=0 for 3 cycles, then toggle it every cycle.
  - Response: rd_data is stable while stalled; no word is lost or duplicated; order is preserved.
- Ignored controls:
  - Stimulus: pulse start in CAPTURE and in DRAIN; pulse sample_valid in DRAIN.
  - Response: counters and pointers are unchanged.
- Reset mid-drain:
  - Stimulus: assert rst after 2 words have been read.
  - Response: next cycle all outputs are 0 and state is IDLE; a new start captures correctly from index 0.

Source files
------------

// File: rtl/adder_vector_logger.sv
// Captures half-adder pin samples as {a, b, sum} vector words, counts sums that
// disagree with a locally computed result, then drains the words over a valid/ready port.
module adder_vector_logger #(
    parameter int DEPTH = 6,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          sample_valid,
    input  logic          a,
    input  logic          b,
    input  logic [1:0]    sum,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [3:0]    rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          full,
    output logic [AW:0]   cap_count,
    output logic [AW:0]   err_count
);

    // state     | meaning
    // S_IDLE    | waiting for start; counters hold results of the last run
    // S_CAPTURE | storing one word per sample_valid
    // S_DRAIN   | presenting mem[rd_ptr] until the last word is accepted
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          last_wr;
    logic          rd_fire;
    logic          sum_bad;

    assign wr_en   = (state == S_CAPTURE) && sample_valid;
    assign last_wr = wr_en && (cap_count == LAST_IDX);
    assign rd_fire = (state == S_DRAIN) && rd_ready;
    assign sum_bad = (sum != {a & b, a ^ b});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (last_wr) begin
                    state_nxt = S_DRAIN;
                end else if (stop) begin
                    // An empty run has nothing to dump, so it goes straight back to idle.
                    state_nxt = (wr_en || (cap_count != '0)) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (rd_fire && rd_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_valid = 1'b0;
        rd_data  = 4'd0;
        rd_last  = 1'b0;
        busy     = (state == S_CAPTURE) || (state == S_DRAIN);
        if (state == S_DRAIN) begin
            rd_valid = 1'b1;
            rd_data  = mem[rd_ptr];
            rd_last  = ({1'b0, rd_ptr} == (cap_count - ONE));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {a, b, sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cap_count <= '0;
            err_count <= '0;
            full      <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                cap_count <= '0;
                err_count <= '0;
                full      <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr    <= wr_ptr + 1'b1;
                cap_count <= cap_count + ONE;
                if (sum_bad) err_count <= err_count + ONE;
                if (last_wr) full <= 1'b1;
            end
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
